// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM encoding, funct3 codes
// and the store-lane helpers used when a store is accepted.
package lsu_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Halfwords must sit on even addresses, words on multiples of four.
    // Unlisted funct3 codes behave as word accesses.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3)
            F3_B, F3_BU: mis = 1'b0;
            F3_H, F3_HU: mis = off[0];
            default:     mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] strb;
        case (f3)
            F3_B, F3_BU: strb = 4'b0001 << off;
            F3_H, F3_HU: strb = 4'b0011 << off;
            default:     strb = 4'b1111;
        endcase
        return strb;
    endfunction

    // Store data replicated to every lane so the strobes alone select bytes.
    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] lanes;
        case (f3)
            F3_B, F3_BU: lanes = {4{d[7:0]}};
            F3_H, F3_HU: lanes = {2{d[15:0]}};
            default:     lanes = d;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus bundle between the load/store unit (master) and memory (slave).
interface lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/halfword out of a read word and extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted_s;
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection and sign/zero extension of the loaded value.
    always_comb begin
        shifted_s = rdata >> {offset, 3'b000};
        byte_s    = shifted_s[7:0];
        half_s    = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    data = {{24{byte_s[7]}}, byte_s};
            F3_H:    data = {{16{half_s[15]}}, half_s};
            F3_BU:   data = {24'h000000, byte_s};
            F3_HU:   data = {16'h0000, half_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns the ALU result into a bus access, stalls the core
// until the access completes, faults on misalignment or times out.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] load_data,
    output logic        lsu_misaligned,
    output logic        lsu_bus_err,
    lsu_if.master       bus
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_e  state_r, state_s;
    logic [15:0] cnt_r;
    logic [31:0] addr_r, wdata_r, ldata_r, align_s;
    logic [3:0]  wstrb_r;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic        we_r, done_r, mis_r, err_r;
    logic        new_op_s, mis_s, timeout_s, busy_s;
    logic        accept_s, mis_set_s, err_set_s, capture_s;

    assign new_op_s  = lsu_valid & (mem_read | mem_write);
    assign mis_s     = is_misaligned(funct3, alu_result[1:0]);
    assign busy_s    = (state_r == S_REQ) | (state_r == S_WAIT);
    assign timeout_s = busy_s & (cnt_r == TO_LAST);

    // Next-state selection and one-cycle event strobes for the FSM.
    always_comb begin
        state_s   = state_r;
        accept_s  = 1'b0;
        mis_set_s = 1'b0;
        err_set_s = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (new_op_s && mis_s) begin
                    state_s   = S_DONE;
                    mis_set_s = 1'b1;
                end else if (new_op_s) begin
                    state_s  = S_REQ;
                    accept_s = 1'b1;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_REQ: begin
                if (timeout_s) begin
                    state_s   = S_DONE;
                    err_set_s = 1'b1;
                end else if (bus.bus_gnt) begin
                    state_s = S_WAIT;
                end else begin
                    state_s = S_REQ;
                end
            end
            S_WAIT: begin
                // A response arriving on the last allowed cycle still counts.
                if (bus.bus_rvalid) begin
                    state_s   = S_DONE;
                    capture_s = 1'b1;
                end else if (timeout_s) begin
                    state_s   = S_DONE;
                    err_set_s = 1'b1;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Access latches captured when a bus access is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r  <= 32'h0000_0000;
            off_r   <= 2'b00;
            f3_r    <= 3'b000;
            we_r    <= 1'b0;
            wdata_r <= 32'h0000_0000;
            wstrb_r <= 4'b0000;
        end else if (accept_s) begin
            addr_r  <= {alu_result[31:2], 2'b00};
            off_r   <= alu_result[1:0];
            f3_r    <= funct3;
            we_r    <= mem_write;
            wdata_r <= mem_write ? store_lanes(funct3, store_data) : 32'h0000_0000;
            wstrb_r <= mem_write ? store_strb(funct3, alu_result[1:0]) : 4'b0000;
        end
    end

    // Timeout counter: cleared on REQ entry, counting through REQ and WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= 16'h0000;
        end else if (accept_s || !busy_s) begin
            cnt_r <= 16'h0000;
        end else begin
            cnt_r <= cnt_r + 16'h0001;
        end
    end

    // Completion outputs, registered so they are valid exactly in DONE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_r  <= 1'b0;
            mis_r   <= 1'b0;
            err_r   <= 1'b0;
            ldata_r <= 32'h0000_0000;
        end else begin
            done_r  <= (state_s == S_DONE);
            mis_r   <= mis_set_s;
            err_r   <= err_set_s;
            ldata_r <= (capture_s && !we_r) ? align_s : 32'h0000_0000;
        end
    end

    lsu_load_align u_load_align (
        .rdata  (bus.bus_rdata),
        .offset (off_r),
        .funct3 (f3_r),
        .data   (align_s)
    );

    assign lsu_stall      = ((state_r == S_IDLE) & new_op_s) | busy_s;
    assign lsu_done       = done_r;
    assign lsu_misaligned = mis_r;
    assign lsu_bus_err    = err_r;
    assign load_data      = ldata_r;

    assign bus.bus_req    = (state_r == S_REQ);
    assign bus.bus_we     = we_r;
    assign bus.bus_addr   = addr_r;
    assign bus.bus_wdata  = wdata_r;
    assign bus.bus_wstrb  = wstrb_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a scripted bus responder.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data;
    logic        lsu_stall, lsu_done, lsu_misaligned, lsu_bus_err;
    logic [31:0] load_data;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    // Results of the most recent run_op call.
    logic [31:0] res_ld, cap_addr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_we, res_mis, res_err, res_saw_req, res_stall0, res_stall_done;
    int          res_cyc, res_reqc, res_stallc;

    lsu_if bus_if ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .lsu_valid      (lsu_valid),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .funct3         (funct3),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .lsu_stall      (lsu_stall),
        .lsu_done       (lsu_done),
        .load_data      (load_data),
        .lsu_misaligned (lsu_misaligned),
        .lsu_bus_err    (lsu_bus_err),
        .bus            (bus_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one memory op and plays the bus: gnt on the gnt_at-th REQ cycle,
    // rvalid on the rv_at-th WAIT cycle (0 = never).
    task automatic run_op(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                          input int gnt_at, input int rv_at, input logic [31:0] rdata);
        int  waitc;
        logic granted, got_done;
        @(negedge clk);
        lsu_valid = 1'b1; mem_read = rd; mem_write = wr;
        funct3 = f3; alu_result = addr; store_data = wd;
        waitc = 0; granted = 1'b0; got_done = 1'b0;
        res_reqc = 0; res_stallc = 0; res_saw_req = 1'b0; res_cyc = -1;
        for (int c = 0; c < 50 && !got_done; c++) begin
            #1;
            if (c == 0) res_stall0 = lsu_stall;
            bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0;
            if (lsu_done) begin
                got_done = 1'b1;
                res_cyc = c; res_ld = load_data; res_mis = lsu_misaligned;
                res_err = lsu_bus_err; res_stall_done = lsu_stall;
                lsu_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
            end else begin
                if (lsu_stall) res_stallc++;
                if (bus_if.bus_req) begin
                    res_reqc++; res_saw_req = 1'b1;
                    cap_addr = bus_if.bus_addr; cap_we = bus_if.bus_we;
                    cap_wstrb = bus_if.bus_wstrb; cap_wdata = bus_if.bus_wdata;
                    if (res_reqc == gnt_at) begin
                        bus_if.bus_gnt = 1'b1; granted = 1'b1;
                    end
                end else if (granted) begin
                    waitc++;
                    if (waitc == rv_at) begin
                        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = rdata;
                    end
                end
                @(negedge clk);
            end
        end
        check_eq({tag, "_done_seen"}, {31'd0, got_done}, 32'd1);
        if (!got_done) begin
            lsu_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0; lsu_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'b000; alu_result = 32'd0; store_data = 32'd0;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_stall", {31'd0, lsu_stall}, 32'd0);
        check_eq("rst_done", {31'd0, lsu_done}, 32'd0);
        check_eq("rst_req", {31'd0, bus_if.bus_req}, 32'd0);
        check_eq("rst_ld", load_data, 32'd0);
        check_eq("rst_strb", {28'd0, bus_if.bus_wstrb}, 32'd0);
        @(negedge clk); rst = 1'b1;

        // LW aligned, minimum latency.
        run_op("lw", 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'd0, 1, 1, 32'hDEAD_BEEF);
        check_eq("lw_stall0", {31'd0, res_stall0}, 32'd1);
        check_eq("lw_stallc", res_stallc, 32'd3);
        check_eq("lw_cyc", res_cyc, 32'd3);
        check_eq("lw_ld", res_ld, 32'hDEAD_BEEF);
        check_eq("lw_addr", cap_addr, 32'h0000_0100);
        check_eq("lw_we", {31'd0, cap_we}, 32'd0);
        check_eq("lw_strb", {28'd0, cap_wstrb}, 32'd0);
        check_eq("lw_stall_done", {31'd0, res_stall_done}, 32'd0);
        check_eq("lw_flags", {30'd0, res_mis, res_err}, 32'd0);

        // SB at top byte lane; rdata garbage must not leak into load_data.
        run_op("sb", 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 1, 32'hFFFF_FFFF);
        check_eq("sb_addr", cap_addr, 32'h0000_0100);
        check_eq("sb_strb", {28'd0, cap_wstrb}, 32'h8);
        check_eq("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
        check_eq("sb_we", {31'd0, cap_we}, 32'd1);
        check_eq("sb_ld", res_ld, 32'd0);

        run_op("lb", 1'b1, 1'b0, 3'b000, 32'h0000_0102, 32'd0, 1, 1, 32'h0080_FF00);
        check_eq("lb_ld", res_ld, 32'hFFFF_FF80);
        run_op("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_0102, 32'd0, 1, 1, 32'h0080_FF00);
        check_eq("lhu_ld", res_ld, 32'h0000_0080);

        // Misaligned accesses: no bus traffic, single stall cycle.
        run_op("lw_mis", 1'b1, 1'b0, 3'b010, 32'h0000_0101, 32'd0, 1, 1, 32'h1111_1111);
        check_eq("lw_mis_req", {31'd0, res_saw_req}, 32'd0);
        check_eq("lw_mis_flag", {31'd0, res_mis}, 32'd1);
        check_eq("lw_mis_cyc", res_cyc, 32'd1);
        check_eq("lw_mis_stallc", res_stallc, 32'd1);
        check_eq("lw_mis_ld", res_ld, 32'd0);
        run_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_0103, 32'd0, 1, 1, 32'h1111_1111);
        check_eq("lh_mis_req", {31'd0, res_saw_req}, 32'd0);
        check_eq("lh_mis_flag", {31'd0, res_mis}, 32'd1);
        run_op("lb_103", 1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 1, 1, 32'h7F00_0000);
        check_eq("lb_103_flag", {31'd0, res_mis}, 32'd0);
        check_eq("lb_103_ld", res_ld, 32'h0000_007F);

        run_op("sh", 1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 1, 1, 32'd0);
        check_eq("sh_strb", {28'd0, cap_wstrb}, 32'hC);
        check_eq("sh_wdata", cap_wdata, 32'hABCD_ABCD);

        // rvalid on the last counted cycle wins over timeout.
        run_op("lh_late", 1'b1, 1'b0, 3'b001, 32'h0000_0102, 32'd0, 2, 2, 32'h8001_0000);
        check_eq("lh_late_err", {31'd0, res_err}, 32'd0);
        check_eq("lh_late_ld", res_ld, 32'hFFFF_8001);
        check_eq("lh_late_cyc", res_cyc, 32'd5);

        // No grant: timeout after 4 REQ cycles.
        run_op("to_req", 1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'd0, 0, 0, 32'd0);
        check_eq("to_req_reqc", res_reqc, 32'd4);
        check_eq("to_req_err", {31'd0, res_err}, 32'd1);
        check_eq("to_req_ld", res_ld, 32'd0);
        check_eq("to_req_cyc", res_cyc, 32'd5);
        // Stray rvalid in IDLE must not produce a completion.
        @(negedge clk);
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'h5555_5555;
        @(negedge clk);
        bus_if.bus_rvalid = 1'b0;
        #1;
        check_eq("stray_done", {31'd0, lsu_done}, 32'd0);
        check_eq("stray_stall", {31'd0, lsu_stall}, 32'd0);

        // Granted but never answered: timeout in WAIT.
        run_op("to_wait", 1'b0, 1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 1, 0, 32'd0);
        check_eq("to_wait_err", {31'd0, res_err}, 32'd1);
        check_eq("to_wait_cyc", res_cyc, 32'd5);
        check_eq("to_wait_strb", {28'd0, cap_wstrb}, 32'hF);

        // Reset while in WAIT aborts immediately.
        @(negedge clk);
        lsu_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; alu_result = 32'h0000_0300;
        @(negedge clk);
        #1;
        check_eq("rw_req", {31'd0, bus_if.bus_req}, 32'd1);
        bus_if.bus_gnt = 1'b1;
        @(negedge clk);
        bus_if.bus_gnt = 1'b0;
        rst = 1'b0; lsu_valid = 1'b0; mem_read = 1'b0;
        #1;
        check_eq("rw_req0", {31'd0, bus_if.bus_req}, 32'd0);
        check_eq("rw_stall0", {31'd0, lsu_stall}, 32'd0);
        check_eq("rw_done0", {31'd0, lsu_done}, 32'd0);
        @(negedge clk); rst = 1'b1;
        run_op("lw_after", 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 1, 1, 32'h1357_9BDF);
        check_eq("lw_after_ld", res_ld, 32'h1357_9BDF);
        check_eq("lw_after_cyc", res_cyc, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
